// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the pipelined slave memory.
package slave_mem_pkg;

    // Controller modes: normal access, or the re-initialisation sweep.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    // Supported read-latency window, in clock cycles.
    localparam int RDLATENCY_MIN = 1;
    localparam int RDLATENCY_MAX = 4;

    // Number of byte lanes in a word of the given width.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/slave_mem_rdpipe.sv
// Read-result delay line: carries a valid flag and its data through STAGES
// registers. Each stage's data register only loads when a valid result passes,
// so the final stage always holds the most recent completed read.
module slave_mem_rdpipe #(
    parameter int DATAWIDTH = 32,
    parameter int STAGES    = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 valid_i,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] data_o
);

    genvar gi;

    generate
        if (STAGES == 0) begin : g_bypass
            assign valid_o = valid_i;
            assign data_o  = data_i;
        end else begin : g_pipe
            for (gi = 0; gi < STAGES; gi++) begin : g_stage
                logic                 valid_q;
                logic [DATAWIDTH-1:0] data_q;
                logic                 valid_in;
                logic [DATAWIDTH-1:0] data_in;

                if (gi == 0) begin : g_first
                    assign valid_in = valid_i;
                    assign data_in  = data_i;
                end else begin : g_chain
                    assign valid_in = g_stage[gi-1].valid_q;
                    assign data_in  = g_stage[gi-1].data_q;
                end

                // One pipeline stage; flush clears both flag and data.
                always_ff @(posedge Clk) begin
                    if (Rst) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end else begin
                        valid_q <= valid_in;
                        if (valid_in) begin
                            data_q <= data_in;
                        end
                    end
                end
            end

            assign valid_o = g_stage[STAGES-1].valid_q;
            assign data_o  = g_stage[STAGES-1].data_q;
        end
    endgenerate

endmodule

// File: rtl/slave_mem_pipelined.sv
// Single-port-write / single-port-read memory with byte enables, a pipelined
// read path of configurable latency and a self-initialising sweep that loads
// every word with its own address.
module slave_mem_pipelined
    import slave_mem_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10,
    parameter int RDLATENCY = 3
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [DATAWIDTH-1:0]   DataIn,
    input  logic [ADDRWIDTH-1:0]   WrAddr,
    input  logic                   Wen,
    input  logic [DATAWIDTH/8-1:0] WrByteEn,
    input  logic [ADDRWIDTH-1:0]   RdAddr,
    input  logic                   Ren,
    input  logic                   Clr,
    output logic [DATAWIDTH-1:0]   DataOut,
    output logic                   RdValid,
    output logic                   InitBusy,
    output logic                   RdDrop
);

    localparam int NBYTES = bytes_per_word(DATAWIDTH);
    localparam int DEPTH  = 2 ** ADDRWIDTH;

    // Reject unsupported configurations at elaboration time.
    if (RDLATENCY < RDLATENCY_MIN || RDLATENCY > RDLATENCY_MAX) begin : g_bad_rdlatency
        $error("slave_mem_pipelined: RDLATENCY must be within 1..4");
    end
    if (DATAWIDTH % 8 != 0) begin : g_bad_datawidth
        $error("slave_mem_pipelined: DATAWIDTH must be a multiple of 8");
    end

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   init_ptr_q, init_ptr_d;
    logic                   rd_drop_q;
    logic                   ram_vld_q;
    logic [DATAWIDTH-1:0]   ram_rd_q;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    logic                   in_init;
    logic                   rd_accept;
    logic [NBYTES-1:0]      wr_be;
    logic [ADDRWIDTH-1:0]   wr_addr;
    logic [DATAWIDTH-1:0]   wr_data;

    assign in_init   = (state_q == ST_INIT);
    assign rd_accept = Ren && !in_init && !Rst;

    // Next-state logic: Clr in IDLE starts a sweep; the sweep ends after the last address.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (Clr) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end
            end
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
    end

    // State and sweep pointer registers; reset always restarts the sweep at address 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Write-port mux: the sweep owns the port while active, otherwise the user's byte-masked write.
    always_comb begin
        wr_be   = '0;
        wr_addr = WrAddr;
        wr_data = DataIn;
        if (!Rst) begin
            if (in_init) begin
                wr_be   = '1;
                wr_addr = init_ptr_q;
                wr_data = DATAWIDTH'(init_ptr_q);
            end else if (Wen) begin
                wr_be = WrByteEn;
            end
        end
    end

    // Memory array write, one byte lane at a time.
    always_ff @(posedge Clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Registered array read; same-edge writes are not visible, so old data is returned.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ram_vld_q <= 1'b0;
            ram_rd_q  <= '0;
        end else begin
            ram_vld_q <= rd_accept;
            if (rd_accept) begin
                ram_rd_q <= mem[RdAddr];
            end
        end
    end

    // Flag reads that arrive while the sweep owns the memory.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_drop_q <= 1'b0;
        end else begin
            rd_drop_q <= Ren && in_init;
        end
    end

    slave_mem_rdpipe #(
        .DATAWIDTH (DATAWIDTH),
        .STAGES    (RDLATENCY - 1)
    ) u_rdpipe (
        .Clk     (Clk),
        .Rst     (Rst),
        .valid_i (ram_vld_q),
        .data_i  (ram_rd_q),
        .valid_o (RdValid),
        .data_o  (DataOut)
    );

    assign InitBusy = in_init;
    assign RdDrop   = rd_drop_q;

endmodule
